// File: rtl/rggen_host_arbiter.sv
// Round-robin arbiter sharing one register-block command port among N_HOSTS requesters.
// Optional BUSY watchdog enabled by defining RGGEN_HOST_ARBITER_TIMEOUT_EN.
module rggen_host_arbiter #(
  parameter int N_HOSTS        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_HOSTS-1:0]                i_command_valid,
  input  logic [N_HOSTS-1:0]                i_write,
  input  logic [N_HOSTS-1:0]                i_read,
  input  logic [N_HOSTS*ADDRESS_WIDTH-1:0]  i_address,
  input  logic [N_HOSTS*DATA_WIDTH/8-1:0]   i_strobe,
  input  logic [N_HOSTS*DATA_WIDTH-1:0]     i_write_data,
  output logic [N_HOSTS-1:0]                o_response_ready,
  output logic [DATA_WIDTH-1:0]             o_read_data,
  output logic [1:0]                        o_status,
  output logic [N_HOSTS-1:0]                o_grant,
  output logic                              o_command_valid,
  output logic                              o_write,
  output logic                              o_read,
  output logic [ADDRESS_WIDTH-1:0]          o_address,
  output logic [DATA_WIDTH/8-1:0]           o_strobe,
  output logic [DATA_WIDTH-1:0]             o_write_data,
  input  logic                              i_response_ready,
  input  logic [DATA_WIDTH-1:0]             i_read_data,
  input  logic [1:0]                        i_status
);

  localparam int IW = (N_HOSTS > 1) ? $clog2(N_HOSTS) : 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   win_idx;
  logic [N_HOSTS-1:0] win_onehot;
  logic            win_found;
  logic            timeout_hit;
  logic            response_fire;

  // Search upward from the pointer with wrap-around; first requester wins.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    int j;
    win_idx    = '0;
    win_onehot = '0;
    win_found  = 1'b0;
    for (int k = 0; k < N_HOSTS; k++) begin
      j = int'(ptr) + k;
      if (j >= N_HOSTS) j -= N_HOSTS;
      if (!win_found && i_command_valid[j]) begin
        win_found     = 1'b1;
        win_idx       = IW'(j);
        win_onehot    = '0;
        win_onehot[j] = 1'b1;
      end
    end
  end

`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
  logic [15:0] busy_count;

  // Zero on the first BUSY cycle, so the watchdog fires on BUSY cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_count <= '0;
    end else if (state != BUSY) begin
      busy_count <= '0;
    end else begin
      busy_count <= busy_count + 16'd1;
    end
  end

  assign timeout_hit = (state == BUSY) && (busy_count == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign response_fire = (state == BUSY) && (i_response_ready || timeout_hit);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = BUSY;
      BUSY:    if (response_fire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command registers, grant and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      grant_idx    <= '0;
      o_grant      <= '0;
      o_write      <= 1'b0;
      o_read       <= 1'b0;
      o_address    <= '0;
      o_strobe     <= '0;
      o_write_data <= '0;
    end else if (state == IDLE && win_found) begin
      grant_idx    <= win_idx;
      o_grant      <= win_onehot;
      o_write      <= i_write[win_idx];
      o_read       <= i_read[win_idx];
      o_address    <= i_address[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      o_strobe     <= i_strobe[win_idx*SW +: SW];
      o_write_data <= i_write_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
    end else if (response_fire) begin
      o_grant <= '0;
      ptr     <= (grant_idx == IW'(N_HOSTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Outputs: a real downstream response takes precedence over the watchdog.
  always_comb begin
    o_command_valid  = (state == BUSY);
    o_response_ready = '0;
    o_read_data      = '0;
    o_status         = 2'b00;
    if (response_fire && !rst) begin
      o_response_ready = o_grant;
      if (i_response_ready) begin
        o_read_data = i_read_data;
        o_status    = i_status;
      end else begin
        o_status    = 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Scoreboard bench for rggen_host_arbiter (N_HOSTS=2); the watchdog test runs only
// when RGGEN_HOST_ARBITER_TIMEOUT_EN is defined.
module tb_rggen_host_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      i_command_valid;
  logic [N-1:0]      i_write;
  logic [N-1:0]      i_read;
  logic [N*AW-1:0]   i_address;
  logic [N*DW/8-1:0] i_strobe;
  logic [N*DW-1:0]   i_write_data;
  logic [N-1:0]      o_response_ready;
  logic [DW-1:0]     o_read_data;
  logic [1:0]        o_status;
  logic [N-1:0]      o_grant;
  logic              o_command_valid;
  logic              o_write;
  logic              o_read;
  logic [AW-1:0]     o_address;
  logic [DW/8-1:0]   o_strobe;
  logic [DW-1:0]     o_write_data;
  logic              i_response_ready;
  logic [DW-1:0]     i_read_data;
  logic [1:0]        i_status;

  rggen_host_arbiter #(
    .N_HOSTS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_command_valid(i_command_valid), .i_write(i_write), .i_read(i_read),
    .i_address(i_address), .i_strobe(i_strobe), .i_write_data(i_write_data),
    .o_response_ready(o_response_ready), .o_read_data(o_read_data), .o_status(o_status),
    .o_grant(o_grant), .o_command_valid(o_command_valid), .o_write(o_write),
    .o_read(o_read), .o_address(o_address), .o_strobe(o_strobe),
    .o_write_data(o_write_data), .i_response_ready(i_response_ready),
    .i_read_data(i_read_data), .i_status(i_status)
  );

  typedef struct {
    int            host;
    logic [DW-1:0] rdata;
    logic [1:0]    status;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   pulse_cyc[$];
  int   n_cmp, n_err, n_pulse, n_push, cyc, model_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every response pulse pops the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (|o_response_ready) begin
      n_pulse++;
      pulse_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(o_response_ready), 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_host",   64'(o_response_ready), 64'(1) << e.host);
        check("resp_data",   64'(o_read_data), 64'(e.rdata));
        check("resp_status", 64'(o_status), 64'(e.status));
        check("resp_grant",  64'(o_grant), 64'(1) << e.host);
        check("resp_addr",   64'(o_address), 64'(e.addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_hosts();
    i_command_valid = '0;
    i_write         = '0;
    i_read          = '0;
    i_address       = '0;
    i_strobe        = '0;
    i_write_data    = '0;
  endtask

  task automatic set_host(input int h, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    i_command_valid[h]        = 1'b1;
    i_write[h]                = wr;
    i_read[h]                 = ~wr;
    i_address[h*AW +: AW]     = addr;
    i_write_data[h*DW +: DW]  = data;
    i_strobe[h*DW/8 +: DW/8]  = strb;
  endtask

  task automatic expect_resp(input int h, input logic [DW-1:0] rd, input logic [1:0] st,
                             input logic [AW-1:0] addr);
    exp_t e;
    e.host = h; e.rdata = rd; e.status = st; e.addr = addr;
    sb.push_back(e);
    n_push++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base, pushed, guard, p0;
    rst = 1'b1;
    clear_hosts();
    i_response_ready = 1'b0;
    i_read_data = '0;
    i_status = '0;
    model_ptr = 0;
    tick(); tick();
    sample();
    check("rst_grant", 64'(o_grant), 64'd0);
    check("rst_cmd_valid", 64'(o_command_valid), 64'd0);
    check("rst_addr", 64'(o_address), 64'd0);
    check("rst_wdata", 64'(o_write_data), 64'd0);
    check("rst_strobe", 64'(o_strobe), 64'd0);
    check("rst_wr_rd", 64'({o_write, o_read}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single host0 write answered on the first BUSY cycle.
    set_host(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    tick();
    clear_hosts();
    i_response_ready = 1'b1;
    expect_resp(0, '0, 2'b00, 8'h04);
    sample();
    check("t1_cmd_valid", 64'(o_command_valid), 64'd1);
    check("t1_wdata", 64'(o_write_data), 64'hDEADBEEF);
    check("t1_strobe", 64'(o_strobe), 64'hF);
    check("t1_write", 64'({o_write, o_read}), 64'b10);
    tick();
    i_response_ready = 1'b0;
    model_ptr = 1;
    sample();
    check("t1_done_valid", 64'(o_command_valid), 64'd0);
    check("t1_done_grant", 64'(o_grant), 64'd0);
    tick();
    sample();
    check("t1_idle_valid", 64'(o_command_valid), 64'd0);
    check("t1_pulses", 64'(n_pulse), 64'd1);

    // Both hosts reading continuously: grants rotate, 3-cycle spacing.
    i_read_data = 32'h0000_00A5;
    i_status = 2'b00;
    set_host(0, 1'b0, 8'h10, '0, 4'h0);
    set_host(1, 1'b0, 8'h20, '0, 4'h0);
    base = pulse_cyc.size();
    pushed = 0;
    guard = 0;
    while (pushed < 4 && guard < 40) begin
      tick();
      guard++;
      i_response_ready = o_command_valid;
      if (o_command_valid) begin
        expect_resp(model_ptr, 32'h0000_00A5, 2'b00, (model_ptr == 1) ? 8'h20 : 8'h10);
        model_ptr = (model_ptr + 1) % N;
        pushed++;
      end
    end
    check("t2_txns", 64'(pushed), 64'd4);
    tick();
    i_response_ready = 1'b0;
    clear_hosts();
    for (int k = 1; k < 4; k++) begin
      if (pulse_cyc.size() > base + k)
        check("t2_spacing", 64'(pulse_cyc[base + k] - pulse_cyc[base + k - 1]), 64'd3);
      else
        check("t2_pulse_missing", 64'(pulse_cyc.size()), 64'(base + 4));
    end
    tick();

    // Host1 read stalled 5 cycles; host0 raised during BUSY must wait until after DONE.
    set_host(1, 1'b0, 8'h33, '0, 4'h0);
    tick();
    clear_hosts();
    set_host(0, 1'b1, 8'h44, 32'h1234_5678, 4'h3);
    for (int s = 0; s < 6; s++) begin
      if (s == 5) begin
        i_response_ready = 1'b1;
        i_read_data = 32'h77;
        expect_resp(1, 32'h77, 2'b00, 8'h33);
      end
      sample();
      check("t3_valid", 64'(o_command_valid), 64'd1);
      check("t3_addr", 64'(o_address), 64'h33);
      check("t3_grant", 64'(o_grant), 64'b10);
      tick();
    end
    i_response_ready = 1'b0;
    model_ptr = 0;
    sample();
    check("t3_done_grant", 64'(o_grant), 64'd0);
    tick();
    sample();
    check("t3_idle_valid", 64'(o_command_valid), 64'd0);
    tick();

    // Host0 now granted; downstream returns error status.
    i_response_ready = 1'b1;
    i_read_data = 32'h55;
    i_status = 2'b10;
    expect_resp(0, 32'h55, 2'b10, 8'h44);
    sample();
    check("t4_grant", 64'(o_grant), 64'b01);
    check("t4_wdata", 64'(o_write_data), 64'h1234_5678);
    clear_hosts();
    tick();
    i_response_ready = 1'b0;
    i_status = 2'b00;
    model_ptr = 1;
    tick();

    // Both request: pointer advanced, so host1 wins; reset lands on BUSY cycle 2.
    set_host(0, 1'b0, 8'h01, '0, 4'h0);
    set_host(1, 1'b0, 8'h02, '0, 4'h0);
    tick();
    sample();
    check("t4_ptr_grant", 64'(o_grant), 64'(1) << model_ptr);
    p0 = n_pulse;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_hosts();
    model_ptr = 0;
    sample();
    check("t5_grant", 64'(o_grant), 64'd0);
    check("t5_valid", 64'(o_command_valid), 64'd0);
    check("t5_addr", 64'(o_address), 64'd0);
    check("t5_no_pulse", 64'(n_pulse), 64'(p0));
    set_host(0, 1'b0, 8'h01, '0, 4'h0);
    set_host(1, 1'b0, 8'h02, '0, 4'h0);
    tick();
    clear_hosts();
    i_response_ready = 1'b1;
    i_read_data = 32'h99;
    expect_resp(0, 32'h99, 2'b00, 8'h01);
    sample();
    check("t5_regrant", 64'(o_grant), 64'b01);
    tick();
    i_response_ready = 1'b0;
    tick();

`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
    // No downstream response: watchdog answers on BUSY cycle TO.
    set_host(0, 1'b1, 8'h66, 32'hCAFE, 4'hF);
    tick();
    clear_hosts();
    i_read_data = 32'hFFFF_FFFF;
    p0 = n_pulse;
    for (int k = 1; k <= TO; k++) begin
      if (k == TO) expect_resp(0, '0, 2'b10, 8'h66);
      sample();
      check("t6_valid", 64'(o_command_valid), 64'd1);
      if (k < TO) check("t6_early", 64'(n_pulse), 64'(p0));
      tick();
    end
    i_response_ready = 1'b1;
    sample();
    check("t6_late_ignored", 64'(n_pulse), 64'(p0 + 1));
    check("t6_done_valid", 64'(o_command_valid), 64'd0);
    tick();
    i_response_ready = 1'b0;
    sample();
    check("t6_idle_valid", 64'(o_command_valid), 64'd0);
`endif

    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("pulse_count", 64'(n_pulse), 64'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
